run_watchdog: RTL and testbench
===============================

# run_watchdog

Parametrised end-of-simulation controller for the top-level harness. It watches the commit stream and N error sources and decides when and why a run ends: halt, error after a drain window, global timeout, or commit-stall hang. It replaces the fixed 1000-cycle countdown and ad-hoc finish logic with one registered block that reports a status code, latched error sources and run statistics.

## Interface
Parameters:
- NUM_ERR, 2, number of external error sources (e.g. monitor, burst memory).
- CNT_W, 32, width of the cycle, commit and limit counters.
- ORDER_W, 64, width of the commit order field.
- DRAIN_CYCLES, 5, cycles held in DRAIN after the first error before reporting done.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- commit_valid  in  1  one instruction retires this cycle.
- commit_order  in  ORDER_W  order of the retiring instruction.
- commit_pc_rdata  in  32  PC of the retiring instruction.
- commit_pc_wdata  in  32  next PC of the retiring instruction.
- err_in  in  NUM_ERR  error flags, sampled every cycle.
- timeout_limit  in  CNT_W  total-cycle limit; 0 disables.
- idle_limit  in  CNT_W  max consecutive cycles without commit; 0 disables.
- done  out  1  run finished; level, held until reset.
- status  out  3  run_status_t: RUN, DRAIN, HALT, ERROR, TIMEOUT, HANG.
- err_latched  out  NUM_ERR+1  sticky error sources; bit NUM_ERR is internal order error.
- cycle_cnt  out  CNT_W  cycles since reset release, saturating.
- commit_cnt  out  CNT_W  commits since reset release, saturating.

## Operation
- States: S_RUN, S_DRAIN, S_DONE. Reset (rst low): S_RUN, done=0, status=RUN, err_latched=0, all counters 0, expected order 0.
- Halt event: commit_valid and commit_pc_rdata == commit_pc_wdata.
- Order error: commit_valid and commit_order != expected order; expected order advances to commit_order+1 on every commit (resync after a mismatch, one error per mismatch).
- Error event: any err_in bit or order error.
- S_RUN, per cycle, priority error > halt > timeout > hang:
  - error: latch sources, status=DRAIN, load drain counter with DRAIN_CYCLES, go S_DRAIN (DRAIN_CYCLES=0: straight to S_DONE, status=ERROR).
  - halt: S_DONE, status=HALT.
  - timeout_limit!=0 and cycle_cnt+1 == timeout_limit: S_DONE, status=TIMEOUT.
  - idle_limit!=0 and idle count reaches idle_limit: S_DONE, status=HANG.
- S_DRAIN: counters and commit tracking continue; new error bits OR into err_latched; halt/timeout/hang ignored; counter decrements, at 1 -> S_DONE, status=ERROR.
- S_DONE: done=1; status, err_latched, counters frozen until reset.
- Idle count: cleared on commit_valid, else increments (saturating).
- All counters saturate at all-ones; no wrap.

## Timing
- All outputs registered. Event sampled at edge k shows done/status at edge k+1 (one-cycle latency).
- Error at edge k: status=DRAIN after k+1, done=1 and status=ERROR after k+1+DRAIN_CYCLES.
- cycle_cnt counts edges in S_RUN/S_DRAIN; first edge after reset release yields 1.
- Asynchronous reset mid-run or mid-drain clears everything immediately, independent of clk.
- Limit inputs are sampled live; changing them mid-run takes effect the next cycle.

## Structure
- run_watchdog_pkg: run_status_t enum (3 bits), state enum, DEFAULT_DRAIN constant.
- One sub-module: sat_counter (parametrised width, clear, enable, saturate), used for cycle, commit and idle counters.

## Test plan
- Halt: commits with order 0..9, commit 9 has pc_rdata=pc_wdata=0x60000040 -> done=1, status=HALT one cycle later, commit_cnt=10, err_latched=0.
- Error drain: err_in=2'b10 at cycle 20, err_in=2'b01 at cycle 22 -> status=DRAIN at 21, done=1/status=ERROR at 26, err_latched=3'b011.
- Timeout: timeout_limit=1000, continuous commits, no halt -> done at cycle 1000, status=TIMEOUT, cycle_cnt=1000.
- Hang: idle_limit=50, last commit at cycle 10 -> status=HANG, done=1 at cycle 61.
- Order skip plus simultaneous halt: commit_order=5 when 4 expected on a halting commit -> error wins, err_latched[NUM_ERR]=1, status ERROR after drain.
- Reset mid-drain: rst low at drain cycle 2 -> done=0, status=RUN, counters 0 immediately; clean halt run afterwards passes.

Source files
------------

// File: rtl/run_watchdog_pkg.sv
// rtl/run_watchdog_pkg.sv - shared types and constants for the run watchdog
package run_watchdog_pkg;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_HALT    = 3'd2,
        ST_ERROR   = 3'd3,
        ST_TIMEOUT = 3'd4,
        ST_HANG    = 3'd5
    } run_status_t;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } wd_state_t;

    localparam int DEFAULT_DRAIN = 5;

endpackage

// File: rtl/run_watchdog_sat_counter.sv
// rtl/run_watchdog_sat_counter.sv - up counter with clear that sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/run_watchdog.sv
// rtl/run_watchdog.sv - decides when and why a simulation run ends
module run_watchdog
    import run_watchdog_pkg::*;
#(
    parameter int NUM_ERR      = 2,
    parameter int CNT_W        = 32,
    parameter int ORDER_W      = 64,
    parameter int DRAIN_CYCLES = DEFAULT_DRAIN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               commit_valid,
    input  logic [ORDER_W-1:0] commit_order,
    input  logic [31:0]        commit_pc_rdata,
    input  logic [31:0]        commit_pc_wdata,
    input  logic [NUM_ERR-1:0] err_in,
    input  logic [CNT_W-1:0]   timeout_limit,
    input  logic [CNT_W-1:0]   idle_limit,
    output logic               done,
    output logic [2:0]         status,
    output logic [NUM_ERR:0]   err_latched,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   commit_cnt
);

    wd_state_t          state_q, state_d;
    run_status_t        status_q, status_d;
    logic [NUM_ERR:0]   err_q, err_d;
    logic [CNT_W-1:0]   drain_q, drain_d;
    logic [ORDER_W-1:0] exp_q, exp_d;
    logic               done_q;
    logic [CNT_W-1:0]   idle_cnt;

    logic             active;
    logic             order_err;
    logic [NUM_ERR:0] err_src;
    logic             err_evt, halt_evt, timeout_evt, hang_evt;

    assign active    = (state_q != S_DONE);
    assign order_err = commit_valid && (commit_order != exp_q);
    assign err_src   = {order_err, err_in};
    assign err_evt   = |err_src;
    assign halt_evt  = commit_valid && (commit_pc_rdata == commit_pc_wdata);

    // Compare one bit wider so a saturated counter never wraps into a false match.
    assign timeout_evt = (timeout_limit != '0) &&
                         (({1'b0, cycle_cnt} + (CNT_W+1)'(1)) == {1'b0, timeout_limit});
    assign hang_evt    = (idle_limit != '0) && !commit_valid &&
                         (({1'b0, idle_cnt} + (CNT_W+1)'(1)) >= {1'b0, idle_limit});

    sat_counter #(.W(CNT_W)) u_cycle (
        .clk (clk), .rst (rst), .clr (1'b0), .en (active), .cnt (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_commit (
        .clk (clk), .rst (rst), .clr (1'b0), .en (active && commit_valid), .cnt (commit_cnt)
    );

    sat_counter #(.W(CNT_W)) u_idle (
        .clk (clk), .rst (rst), .clr (active && commit_valid), .en (active), .cnt (idle_cnt)
    );

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        err_d    = err_q;
        drain_d  = drain_q;
        exp_d    = exp_q;
        if (active && commit_valid) begin
            exp_d = commit_order + ORDER_W'(1);
        end
        case (state_q)
            S_RUN: begin
                if (err_evt) begin
                    err_d = err_q | err_src;
                    if (DRAIN_CYCLES == 0) begin
                        state_d  = S_DONE;
                        status_d = ST_ERROR;
                    end else begin
                        state_d  = S_DRAIN;
                        status_d = ST_DRAIN;
                        drain_d  = CNT_W'(DRAIN_CYCLES);
                    end
                end else if (halt_evt) begin
                    state_d  = S_DONE;
                    status_d = ST_HALT;
                end else if (timeout_evt) begin
                    state_d  = S_DONE;
                    status_d = ST_TIMEOUT;
                end else if (hang_evt) begin
                    state_d  = S_DONE;
                    status_d = ST_HANG;
                end
            end
            S_DRAIN: begin
                err_d = err_q | err_src;
                if (drain_q <= CNT_W'(1)) begin
                    state_d  = S_DONE;
                    status_d = ST_ERROR;
                end else begin
                    drain_d = drain_q - CNT_W'(1);
                end
            end
            S_DONE: begin
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_RUN;
            status_q <= ST_RUN;
            err_q    <= '0;
            drain_q  <= '0;
            exp_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            err_q    <= err_d;
            drain_q  <= drain_d;
            exp_q    <= exp_d;
            done_q   <= (state_d == S_DONE);
        end
    end

    assign done        = done_q;
    assign status      = status_q;
    assign err_latched = err_q;

endmodule

// File: tb/tb_run_watchdog.sv
// tb/tb_run_watchdog.sv - directed bench for run_watchdog with a reference model
module tb_run_watchdog;

    localparam int S_RUN_V = 0, S_DRAIN_V = 1, S_HALT_V = 2, S_ERROR_V = 3, S_TIMEOUT_V = 4, S_HANG_V = 5;
    localparam int DRAIN = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid;
    logic [63:0] commit_order;
    logic [31:0] commit_pc_rdata, commit_pc_wdata;
    logic [1:0]  err_in;
    logic [31:0] timeout_limit, idle_limit;
    logic        done;
    logic [2:0]  status;
    logic [2:0]  err_latched;
    logic [31:0] cycle_cnt, commit_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    run_watchdog dut (
        .clk             (clk),
        .rst             (rst),
        .commit_valid    (commit_valid),
        .commit_order    (commit_order),
        .commit_pc_rdata (commit_pc_rdata),
        .commit_pc_wdata (commit_pc_wdata),
        .err_in          (err_in),
        .timeout_limit   (timeout_limit),
        .idle_limit      (idle_limit),
        .done            (done),
        .status          (status),
        .err_latched     (err_latched),
        .cycle_cnt       (cycle_cnt),
        .commit_cnt      (commit_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: tracks the run in plain integers and decides the end reason.
    bit          m_done     = 0;
    int          m_status   = S_RUN_V;
    longint      m_cycles   = 0;
    longint      m_commits  = 0;
    longint      m_idle     = 0;
    int          m_left     = 0;
    logic [2:0]  m_err      = '0;
    logic [63:0] m_exp      = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_done = 0; m_status = S_RUN_V; m_cycles = 0; m_commits = 0;
            m_idle = 0; m_left = 0; m_err = '0; m_exp = '0;
        end else if (!m_done) begin
            logic [2:0] srcs;
            srcs = {commit_valid && (commit_order != m_exp), err_in};
            m_cycles++;
            if (commit_valid) begin
                m_commits++;
                m_exp  = commit_order + 64'd1;
                m_idle = 0;
            end else begin
                m_idle++;
            end
            if (m_status == S_DRAIN_V) begin
                m_err = m_err | srcs;
                m_left--;
                if (m_left == 0) begin m_done = 1; m_status = S_ERROR_V; end
            end else if (srcs != 0) begin
                m_err = m_err | srcs; m_status = S_DRAIN_V; m_left = DRAIN;
            end else if (commit_valid && commit_pc_rdata == commit_pc_wdata) begin
                m_done = 1; m_status = S_HALT_V;
            end else if (timeout_limit != 0 && m_cycles == longint'(timeout_limit)) begin
                m_done = 1; m_status = S_TIMEOUT_V;
            end else if (idle_limit != 0 && m_idle >= longint'(idle_limit)) begin
                m_done = 1; m_status = S_HANG_V;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            n_checks++;
            if (done == m_done && int'(status) == m_status && err_latched == m_err &&
                longint'(cycle_cnt) == m_cycles && longint'(commit_cnt) == m_commits) begin
                n_pass++;
            end else begin
                $display("FAIL model_cmp t=%0t: got done=%0d st=%0d err=%b cyc=%0d com=%0d expected done=%0d st=%0d err=%b cyc=%0d com=%0d",
                         $time, done, status, err_latched, cycle_cnt, commit_cnt,
                         m_done, m_status, m_err, m_cycles, m_commits);
            end
        end
    end

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit v, input logic [63:0] ord, input logic [31:0] rd, input logic [31:0] wd);
        commit_valid    = v;
        commit_order    = ord;
        commit_pc_rdata = rd;
        commit_pc_wdata = wd;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(0, 0, 0, 0);
        err_in = 2'b00; timeout_limit = 0; idle_limit = 0;
        #1;
        chk("rst_done", done, 0);
        chk("rst_status", status, S_RUN_V);
        chk("rst_err", err_latched, 0);
        chk("rst_cycle", cycle_cnt, 0);
        chk("rst_commit", commit_cnt, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic run_halt();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c == 9) drive(1, 64'(c), 32'h6000_0040, 32'h6000_0040);
            else        drive(1, 64'(c), 32'h6000_0000 + 32'(4*c), 32'h6000_0004 + 32'(4*c));
            if (c == 9) chk("halt_not_yet", done, 0);
            tick();
        end
        drive(0, 0, 0, 0);
        chk("halt_done", done, 1);
        chk("halt_status", status, S_HALT_V);
        chk("halt_commits", commit_cnt, 10);
        chk("halt_err", err_latched, 0);
        repeat (3) tick();
        chk("halt_frozen_cycle", cycle_cnt, 10);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0);
        err_in = 2'b00; timeout_limit = 0; idle_limit = 0;
        #3;

        run_halt();

        // Error drain with a second source arriving mid-drain
        do_reset();
        for (int c = 0; c <= 30; c++) begin
            err_in = (c == 20) ? 2'b10 : (c == 22) ? 2'b01 : 2'b00;
            if (c == 20) chk("drain_pre", status, S_RUN_V);
            if (c == 21) begin chk("drain_status", status, S_DRAIN_V); chk("drain_done0", done, 0); end
            if (c == 25) chk("drain_still", done, 0);
            if (c == 26) begin
                chk("drain_done", done, 1);
                chk("drain_err_status", status, S_ERROR_V);
                chk("drain_err_bits", err_latched, 3'b011);
            end
            tick();
        end
        err_in = 2'b00;

        // Global timeout with continuous commits
        do_reset();
        timeout_limit = 1000;
        for (int c = 0; c <= 1002; c++) begin
            drive(1, 64'(c), 32'h1000 + 32'(4*c), 32'h1004 + 32'(4*c));
            if (c == 999) chk("to_not_yet", done, 0);
            if (c == 1000) begin
                chk("to_done", done, 1);
                chk("to_status", status, S_TIMEOUT_V);
                chk("to_cycles", cycle_cnt, 1000);
            end
            tick();
        end

        // Commit-stall hang
        do_reset();
        idle_limit = 50;
        for (int c = 0; c <= 65; c++) begin
            if (c <= 10) drive(1, 64'(c), 32'h2000 + 32'(4*c), 32'h2004 + 32'(4*c));
            else         drive(0, 0, 0, 0);
            if (c == 60) chk("hang_not_yet", done, 0);
            if (c == 61) begin chk("hang_done", done, 1); chk("hang_status", status, S_HANG_V); end
            tick();
        end

        // Order skip on a halting commit: error beats halt
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            if (c < 4)       drive(1, 64'(c), 32'h3000 + 32'(4*c), 32'h3004 + 32'(4*c));
            else if (c == 4) drive(1, 64'd5, 32'h6000_0040, 32'h6000_0040);
            else             drive(0, 0, 0, 0);
            if (c == 5) begin
                chk("skip_status", status, S_DRAIN_V);
                chk("skip_err", err_latched, 3'b100);
                chk("skip_done0", done, 0);
            end
            if (c == 10) begin
                chk("skip_done", done, 1);
                chk("skip_final", status, S_ERROR_V);
                chk("skip_commits", commit_cnt, 5);
            end
            tick();
        end

        // Asynchronous reset in the middle of a drain window
        do_reset();
        for (int c = 0; c < 5; c++) begin
            if (c < 3) drive(1, 64'(c), 32'h4000 + 32'(4*c), 32'h4004 + 32'(4*c));
            else       drive(0, 0, 0, 0);
            err_in = (c == 3) ? 2'b01 : 2'b00;
            if (c == 4) chk("mid_drain", status, S_DRAIN_V);
            tick();
        end
        rst = 1'b0;
        #1;
        chk("arst_done", done, 0);
        chk("arst_status", status, S_RUN_V);
        chk("arst_cycle", cycle_cnt, 0);
        chk("arst_commit", commit_cnt, 0);
        chk("arst_err", err_latched, 0);
        run_halt();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
